// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - PC owner with branch evaluation, stall-parked redirect and flush pulse
module branch_redirect_unit #(
    parameter int              PC_W     = 16,
    parameter int              OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [1:0]       br_cond,
    input  logic [15:0]      br_result,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_offset,
    output logic             imem_req,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             redirect_pending,
    output logic [15:0]      taken_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q;
    logic            run_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_target_q;
    logic            flush_q;
    logic            pending_q;
    logic [15:0]     taken_cnt_q;

    logic            cond_true;
    logic            taken;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] seq_pc;
    logic [15:0]     cnt_inc;

    // Branch condition decode from the ID-stage compare result
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            2'b00:   cond_true = (br_result == 16'h0000);
            2'b01:   cond_true = (br_result != 16'h0000);
            2'b10:   cond_true = br_result[15];
            default: cond_true = 1'b1;
        endcase
    end

    // Target, sequential PC and saturating counter increment
    always_comb begin
        taken   = br_valid & cond_true;
        off_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
        target  = br_pc + PC_W'(PC_STEP) + (off_ext << 1);
        seq_pc  = pc_q + PC_W'(PC_STEP);
        cnt_inc = (taken_cnt_q == 16'hFFFF) ? taken_cnt_q : taken_cnt_q + 16'd1;
    end

    // Redirect FSM: IDLE fetches/redirects, HOLD parks a redirect seen under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            flush_q       <= 1'b0;
            pending_q     <= 1'b0;
            taken_cnt_q   <= 16'h0000;
        end else if (!run_q) begin
            run_q   <= 1'b1;
            flush_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        if (taken) begin
                            pc_q        <= target;
                            flush_q     <= 1'b1;
                            taken_cnt_q <= cnt_inc;
                        end else begin
                            pc_q <= seq_pc;
                        end
                    end else if (taken) begin
                        pend_target_q <= target;
                        pending_q     <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    // The frozen ID stage re-presents the same branch, so inputs are ignored here
                    if (!stall) begin
                        pc_q        <= pend_target_q;
                        flush_q     <= 1'b1;
                        taken_cnt_q <= cnt_inc;
                        pending_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req         = run_q & ~stall;
    assign pc               = pc_q;
    assign flush            = flush_q;
    assign redirect_pending = pending_q;
    assign taken_cnt        = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - scoreboard bench with behavioural PC/redirect model
module tb_branch_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_cond;
    logic [15:0] br_result;
    logic [15:0] br_pc;
    logic [7:0]  br_offset;
    logic        imem_req;
    logic [15:0] pc;
    logic        flush;
    logic        redirect_pending;
    logic [15:0] taken_cnt;

    branch_redirect_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .br_valid         (br_valid),
        .br_cond          (br_cond),
        .br_result        (br_result),
        .br_pc            (br_pc),
        .br_offset        (br_offset),
        .imem_req         (imem_req),
        .pc               (pc),
        .flush            (flush),
        .redirect_pending (redirect_pending),
        .taken_cnt        (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int flush;
        int pend;
        int imem;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state
    int m_run;
    int m_pc;
    int m_flush;
    int m_parked;
    int m_park_target;
    int m_cnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int branch_taken(input int valid, input int cond, input int res);
        if (valid == 0) return 0;
        case (cond)
            0: return (res == 0) ? 1 : 0;
            1: return (res != 0) ? 1 : 0;
            2: return (res >= 32768) ? 1 : 0;
            default: return 1;
        endcase
    endfunction

    function automatic int branch_target(input int bpc, input int off);
        int soff;
        soff = (off >= 128) ? off - 256 : off;
        return (bpc + 2 + soff * 2 + 65536 * 4) % 65536;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rise
    task automatic drive(input int rst, input int stl, input int vld, input int cond,
                         input int res, input int bpc, input int off);
        exp_t e;
        int   tk;
        int   tgt;
        @(negedge clk);
        rst_n     = rst[0];
        stall     = stl[0];
        br_valid  = vld[0];
        br_cond   = cond[1:0];
        br_result = res[15:0];
        br_pc     = bpc[15:0];
        br_offset = off[7:0];
        tk  = branch_taken(vld, cond, res);
        tgt = branch_target(bpc, off);
        if (rst == 0) begin
            m_run = 0; m_pc = 0; m_flush = 0; m_parked = 0; m_cnt = 0;
        end else if (m_run == 0) begin
            m_run = 1;
        end else begin
            m_flush = 0;
            if (m_parked != 0) begin
                if (stl == 0) begin
                    m_pc = m_park_target; m_flush = 1; m_parked = 0;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else if (stl == 0) begin
                if (tk != 0) begin
                    m_pc = tgt; m_flush = 1;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_pc = (m_pc + 2) % 65536;
                end
            end else if (tk != 0) begin
                m_park_target = tgt; m_parked = 1;
            end
        end
        e.pc    = m_pc;
        e.flush = m_flush;
        e.pend  = m_parked;
        e.imem  = (m_run != 0 && stl == 0) ? 1 : 0;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every DUT cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("flush", int'(flush), e.flush);
                chk("redirect_pending", int'(redirect_pending), e.pend);
                chk("imem_req", int'(imem_req), e.imem);
                chk("taken_cnt", int'(taken_cnt), e.cnt);
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_cond = 2'b00;
        br_result = 16'h0; br_pc = 16'h0; br_offset = 8'h0;
        m_run = 0; m_pc = 0; m_flush = 0; m_parked = 0; m_park_target = 0; m_cnt = 0;

        // Reset, then sequential fetch
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(6);

        // BEQ taken from pc 0010, then BEQ not taken
        guard = 0;
        while (m_pc != 16'h0010 && guard < 20) begin idle(1); guard++; end
        chk("reach_pc_0010", m_pc, 16'h0010);
        drive(1, 0, 1, 0, 16'h0000, 16'h000E, 8'h04);
        idle(1);
        drive(1, 0, 1, 0, 16'h0005, 16'h000E, 8'h04);
        idle(1);

        // BLT backwards, then wrap via JMP to FFFE
        drive(1, 0, 1, 2, 16'h8001, 16'h0040, 8'hF8);
        idle(1);
        drive(1, 0, 1, 3, 16'h1234, 16'hFFFC, 8'h00);
        idle(2);

        // JMP under 3-cycle stall, then release
        drive(1, 1, 1, 3, 0, 16'h0100, 8'h10);
        drive(1, 1, 1, 3, 0, 16'h0100, 8'h10);
        drive(1, 1, 1, 3, 0, 16'h0100, 8'h10);
        drive(1, 0, 1, 3, 0, 16'h0100, 8'h10);
        idle(3);

        // Enter HOLD, then reset mid-stall; immediate async reset check
        drive(1, 1, 1, 3, 0, 16'h0200, 8'h20);
        drive(1, 1, 1, 3, 0, 16'h0200, 8'h20);
        drive(0, 1, 1, 3, 0, 16'h0200, 8'h20);
        #1;
        chk("async_reset_pc", int'(pc), 0);
        chk("async_reset_pending", int'(redirect_pending), 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        idle(5);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            int r;
            int res;
            r   = int'($urandom_range(0, 3));
            res = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535));
            drive(($urandom_range(0, 199) == 0) ? 0 : 1,
                  (r == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  res,
                  int'($urandom_range(0, 32767)) * 2,
                  int'($urandom_range(0, 255)));
        end

        // Saturation: 65534 redirects, then 3 more
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) drive(1, 0, 1, 3, 0, 16'h0400, 8'h02);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 3, 0, 16'h0400, 8'h02);
        idle(1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        #2;
        if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        chk("taken_cnt_saturated", int'(taken_cnt), 16'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
